// File: rtl/if_fetch.sv
// Instruction fetch stage: pulls one 32-bit instruction per PC as four little-endian
// byte reads and hands instruction plus PC to the IF/ID boundary.
module if_fetch #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic              stall_req_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_done_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              stall_i,
  input  logic              flush_i
);

  // state | meaning
  // IDLE  | waiting for a PC from the PC stage
  // FETCH | byte read k of 0..3 outstanding
  // OUT   | instruction presented, waiting for ID to accept
  // DRAIN | flushed while a byte read was in flight; waiting for it to finish
  typedef enum logic [1:0] {IDLE, FETCH, OUT, DRAIN} state_t;

  state_t            state, state_n;
  logic [1:0]        k, k_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [ADDR_W-1:0] addr_n, inst_pc_n;
  logic [23:0]       asm_q, asm_n;
  logic [31:0]       inst_n;
  logic              re_n, valid_n;

  assign stall_req_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      base         <= '0;
      asm_q        <= '0;
      mem_re_o     <= 1'b0;
      mem_addr_o   <= '0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      base         <= base_n;
      asm_q        <= asm_n;
      mem_re_o     <= re_n;
      mem_addr_o   <= addr_n;
      inst_o       <= inst_n;
      inst_pc_o    <= inst_pc_n;
      inst_valid_o <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    k_n       = k;
    base_n    = base;
    asm_n     = asm_q;
    re_n      = mem_re_o;
    addr_n    = mem_addr_o;
    inst_n    = inst_o;
    inst_pc_n = inst_pc_o;
    valid_n   = inst_valid_o;
    case (state)
      IDLE: begin
        if (ce_i && !flush_i) begin
          base_n  = pc_i;
          addr_n  = pc_i;
          re_n    = 1'b1;
          k_n     = 2'd0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        // A flush wins over completion; an outstanding read must still be drained.
        if (flush_i) begin
          if (mem_done_i) begin
            re_n    = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = DRAIN;
          end
        end else if (mem_done_i) begin
          if (k == 2'd3) begin
            re_n      = 1'b0;
            inst_n    = {mem_rdata_i, asm_q};
            inst_pc_n = base;
            valid_n   = 1'b1;
            state_n   = OUT;
          end else begin
            case (k)
              2'd0:    asm_n[7:0]   = mem_rdata_i;
              2'd1:    asm_n[15:8]  = mem_rdata_i;
              default: asm_n[23:16] = mem_rdata_i;
            endcase
            k_n    = k + 2'd1;
            addr_n = mem_addr_o + ADDR_W'(1);
          end
        end
      end
      OUT: begin
        if (flush_i || !stall_i) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (mem_done_i) begin
          re_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory responder with programmable wait states and a
// transaction-level model of what each fetch must return and when.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic        stall_req_o;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_rdata_i = '0;
  logic        mem_done_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;

  if_fetch #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall_req_o(stall_req_o),
    .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .mem_done_i(mem_done_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .stall_i(stall_i), .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] addrq [$];
  int          wait_n = 0;
  bit          force_done = 1'b0;
  int          stab_err = 0;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: answers each request wait_n cycles after it appears.
  initial begin
    int cnt = 0;
    logic [31:0] held = '0;
    forever begin
      @(negedge clk);
      if (force_done) begin
        mem_done_i  = 1'b1;
        mem_rdata_i = 8'hAA;
        cnt = 0;
      end else if (mem_re_o === 1'b1) begin
        if (cnt == 0) held = mem_addr_o;
        else if (mem_addr_o !== held) stab_err++;
        if (cnt >= wait_n) begin
          mem_done_i  = 1'b1;
          mem_rdata_i = rd(mem_addr_o);
          addrq.push_back(mem_addr_o);
          cnt = 0;
        end else begin
          mem_done_i = 1'b0;
          cnt++;
        end
      end else begin
        mem_done_i = 1'b0;
        cnt = 0;
      end
    end
  end

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_fetch(input logic [31:0] pc, input int w, input int s);
    int lat;
    int bad;
    logic [31:0] exp;
    wait_n = w;
    addrq.delete();
    stab_err = 0;
    ce_i = 1'b1;
    pc_i = pc;
    @(negedge clk);
    ce_i = 1'b0;
    pc_i = $urandom;
    chk("cap_stall_req", 32'(stall_req_o), 32'd1);
    chk("cap_mem_re", 32'(mem_re_o), 32'd1);
    chk("cap_mem_addr", mem_addr_o, pc);
    lat = 0;
    bad = 0;
    while (inst_valid_o !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (stall_req_o !== 1'b1) bad++;
    end
    chk("latency", 32'(lat), 32'(4 * (w + 1)));
    chk("stall_req_during_fetch", 32'(bad), 32'd0);
    exp = {rd(pc + 32'd3), rd(pc + 32'd2), rd(pc + 32'd1), rd(pc)};
    chk("inst", inst_o, exp);
    chk("inst_pc", inst_pc_o, pc);
    chk("re_low_in_out", 32'(mem_re_o), 32'd0);
    chk("byte_reads", 32'(addrq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("byte_addr", (addrq.size() > i) ? addrq[i] : 32'hxxxxxxxx, pc + 32'(i));
    chk("addr_stable_in_wait", 32'(stab_err), 32'd0);
    stall_i = (s > 0);
    for (int i = 0; i < s; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(inst_valid_o), 32'd1);
      chk("hold_inst", inst_o, exp);
      chk("hold_pc", inst_pc_o, pc);
      chk("hold_re", 32'(mem_re_o), 32'd0);
      chk("hold_stall_req", 32'(stall_req_o), 32'd1);
      if (i == s - 1) stall_i = 1'b0;
    end
    @(negedge clk);
    chk("consumed_valid", 32'(inst_valid_o), 32'd0);
    chk("consumed_idle", 32'(stall_req_o), 32'd0);
    chk("inst_kept", inst_o, exp);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_stall_req", 32'(stall_req_o), 32'd0);
    chk("rst_mem_re", 32'(mem_re_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
  endtask

  initial begin
    int t;
    int seen;
    mem[32'h0] = 8'h13; mem[32'h1] = 8'h05; mem[32'h2] = 8'h10; mem[32'h3] = 8'h00;
    mem[32'h4] = 8'h93; mem[32'h5] = 8'h00; mem[32'h6] = 8'h10; mem[32'h7] = 8'h00;

    // Reset with fetch enable and done both forced high
    @(negedge clk);
    rst = 1'b1; ce_i = 1'b1; pc_i = 32'h0; force_done = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    force_done = 1'b0;

    // Zero-wait fetch captured on the first edge after release
    do_fetch(32'h0000_0000, 0, 0);
    chk("zero_wait_word", inst_o, 32'h0010_0513);

    // Three wait cycles per byte and a three-cycle downstream stall
    do_fetch(32'h0000_0004, 3, 3);
    chk("wait_state_word", inst_o, 32'h0010_0093);

    // Flush while byte 2 is outstanding
    wait_n = 3;
    addrq.delete();
    stab_err = 0;
    ce_i = 1'b1; pc_i = 32'h0000_0030;
    @(negedge clk);
    ce_i = 1'b0;
    t = 0;
    while (addrq.size() < 2 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("drain_stall_req", 32'(stall_req_o), 32'd1);
    chk("drain_re_held", 32'(mem_re_o), 32'd1);
    chk("drain_addr_held", mem_addr_o, 32'h0000_0032);
    t = 0;
    seen = 0;
    while (stall_req_o !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
      if (inst_valid_o === 1'b1) seen++;
    end
    chk("drain_done_re", 32'(mem_re_o), 32'd0);
    chk("flush_no_valid", 32'(seen), 32'd0);
    chk("drain_reads", 32'(addrq.size()), 32'd3);
    chk("drain_addr_stable", 32'(stab_err), 32'd0);
    do_fetch(32'h0000_0040, 1, 0);

    // Flush in IDLE blocks the capture
    ce_i = 1'b1; flush_i = 1'b1; pc_i = 32'h0000_0200;
    @(negedge clk);
    ce_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush_stall_req", 32'(stall_req_o), 32'd0);
    chk("idle_flush_re", 32'(mem_re_o), 32'd0);

    // Flush in OUT overrides a downstream stall
    wait_n = 0;
    ce_i = 1'b1; pc_i = 32'h0000_0080;
    @(negedge clk);
    ce_i = 1'b0;
    t = 0;
    while (inst_valid_o !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("out_reached", 32'(inst_valid_o), 32'd1);
    stall_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    stall_i = 1'b0; flush_i = 1'b0;
    chk("out_flush_valid", 32'(inst_valid_o), 32'd0);
    chk("out_flush_idle", 32'(stall_req_o), 32'd0);

    // Address wraps past the top of memory
    do_fetch(32'hFFFF_FFFE, 1, 1);

    for (int i = 0; i < 8; i++)
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 2));

    // Reset in the middle of a fetch
    wait_n = 2;
    ce_i = 1'b1; pc_i = 32'h0000_0500;
    @(negedge clk);
    ce_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; force_done = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0; force_done = 1'b0;
    do_fetch(32'h0000_0004, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
